// File: rtl/refresh_scheduler.sv
// ---------------------------------------------------------------------------
// refresh_scheduler
//
// Decides when a DRAM controller owes AUTO REFRESH commands. It runs an
// initialisation burst of INIT_REFRESHES refreshes first. After that it keeps
// a periodic interval counter, and each expiry adds one refresh to a
// pending count. The command sequencer pays refreshes back through ref_ack.
//
// Parameters
//   SIZE           width of the interval counter and refresh_period
//   INIT_REFRESHES refreshes owed by the initialisation burst (1..8)
//   URGENT_THRESH  pending level at or above which ref_urgent is raised (1..8)
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   enable         starts the scheduler from IDLE; pauses the counter in RUN
//   refresh_period interval in clk cycles, 0 disables periodic refresh
//   ref_ack        one refresh issued; only counted while ref_req is high
//   ref_req        at least one refresh is owed
//   ref_urgent     pending_count >= URGENT_THRESH
//   pending_count  number of owed refreshes, 0..8
//   init_done      initialisation burst complete
//   overflow       sticky: a periodic tick was lost at pending_count = 8
// ---------------------------------------------------------------------------
module refresh_scheduler #(
  parameter int SIZE           = 16,
  parameter int INIT_REFRESHES = 2,
  parameter int URGENT_THRESH  = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [SIZE-1:0] refresh_period,
  input  logic            ref_ack,
  output logic            ref_req,
  output logic            ref_urgent,
  output logic [3:0]      pending_count,
  output logic            init_done,
  output logic            overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [3:0]      INIT_VAL    = 4'(INIT_REFRESHES);
  localparam logic [3:0]      URGENT_VAL  = 4'(URGENT_THRESH);
  localparam logic [3:0]      PENDING_MAX = 4'd8;
  localparam logic [SIZE-1:0] ONE         = SIZE'(1);

  state_t          state;
  logic [SIZE-1:0] count;

  logic            ack_ok;
  logic            tick;
  logic            tick_lost;
  logic [3:0]      pend_next;

  // An ack is only meaningful while something is owed, so a stray ack at
  // zero can never underflow the count.
  assign ack_ok = ref_ack && (pending_count != 4'd0);

  // The ">=" compare (not "==") makes a period that is lowered below the
  // current count expire on the next cycle instead of wrapping the counter.
  always_comb begin
    tick = 1'b0;
    if (state == RUN && enable && refresh_period != '0 &&
        count >= refresh_period - ONE) begin
      tick = 1'b1;
    end
  end

  // Next pending level. In RUN, a tick and an accepted ack in the same cycle
  // cancel each other out. A tick that arrives at the ceiling is dropped and
  // flagged.
  always_comb begin
    pend_next = pending_count;
    tick_lost = 1'b0;
    unique case (state)
      IDLE: pend_next = enable ? INIT_VAL : 4'd0;
      INIT: begin
        if (ack_ok) begin
          pend_next = pending_count - 4'd1;
        end
      end
      RUN: begin
        if (tick && !ack_ok) begin
          if (pending_count == PENDING_MAX) begin
            tick_lost = 1'b1;
          end else begin
            pend_next = pending_count + 4'd1;
          end
        end else if (ack_ok && !tick) begin
          pend_next = pending_count - 4'd1;
        end
      end
      default: pend_next = 4'd0;
    endcase
  end

  // Main state register. ref_req and ref_urgent are registered from the
  // next pending level, so they always agree with pending_count and never
  // depend combinationally on the inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      count         <= '0;
      pending_count <= 4'd0;
      ref_req       <= 1'b0;
      ref_urgent    <= 1'b0;
      init_done     <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      pending_count <= pend_next;
      ref_req       <= (pend_next != 4'd0);
      ref_urgent    <= (pend_next >= URGENT_VAL);
      if (tick_lost) begin
        overflow <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          count <= '0;
          if (enable) begin
            state <= INIT;
          end
        end
        INIT: begin
          count <= '0;
          if (ack_ok && pending_count == 4'd1) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          // A zero period parks the counter at 0. A low enable freezes it
          // at its current value.
          if (refresh_period == '0) begin
            count <= '0;
          end else if (enable) begin
            count <= tick ? '0 : count + ONE;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_refresh_scheduler.sv
// ---------------------------------------------------------------------------
// tb_refresh_scheduler
//
// Directed bench for refresh_scheduler with default parameters
// (INIT_REFRESHES = 2, URGENT_THRESH = 6). A vector table covers
// init, ticks, acks and pausing. Hand-written sequences cover urgency,
// saturation, pause/resume, period changes and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_refresh_scheduler;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] refresh_period;
  logic        ref_ack;
  logic        ref_req;
  logic        ref_urgent;
  logic [3:0]  pending_count;
  logic        init_done;
  logic        overflow;

  int total;
  int bad;

  refresh_scheduler #(
    .SIZE(16),
    .INIT_REFRESHES(2),
    .URGENT_THRESH(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .refresh_period(refresh_period),
    .ref_ack(ref_ack),
    .ref_req(ref_req),
    .ref_urgent(ref_urgent),
    .pending_count(pending_count),
    .init_done(init_done),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [15:0] per;
    logic        ack;
    logic        req;
    logic        urg;
    logic [3:0]  pend;
    logic        done;
    logic        ovf;
  } vec_t;

  vec_t vecs[19];

  // Advance one clock and sample 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic en, input logic [15:0] per, input logic ack);
    enable         = en;
    refresh_period = per;
    ref_ack        = ack;
  endtask

  task automatic check_output(input string name, input logic req, input logic urg,
                              input logic [3:0] pend, input logic done, input logic ovf);
    logic [7:0] got;
    logic [7:0] exp;
    got = {ref_req, ref_urgent, pending_count, init_done, overflow};
    exp = {req, urg, pend, done, ovf};
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got req=%b urg=%b pend=%0d done=%b ovf=%b, expected req=%b urg=%b pend=%0d done=%b ovf=%b",
               name, ref_req, ref_urgent, pending_count, init_done, overflow,
               req, urg, pend, done, ovf);
    end
  endtask

  task automatic do_reset();
    apply_stimulus(1'b0, 16'd0, 1'b0);
    rst = 1'b1;
    step();
    check_output("reset", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // Leaves the block in RUN with the counter at 0 and nothing owed.
  task automatic run_init(input logic [15:0] per);
    apply_stimulus(1'b1, per, 1'b0);
    step();
    check_output("init_start", 1'b1, 1'b0, 4'd2, 1'b0, 1'b0);
    ref_ack = 1'b1;
    step();
    step();
    ref_ack = 1'b0;
    check_output("init_done", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    apply_stimulus(1'b0, 16'd0, 1'b0);

    // en  per  ack | req urg pend done ovf
    vecs[0]  = '{1'b0, 16'd4, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}; // idle waits
    vecs[1]  = '{1'b0, 16'd4, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}; // stray ack in idle
    vecs[2]  = '{1'b1, 16'd4, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0}; // enter INIT
    vecs[3]  = '{1'b0, 16'd4, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0}; // ack 1
    vecs[4]  = '{1'b0, 16'd4, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0}; // no ticks in INIT
    vecs[5]  = '{1'b0, 16'd4, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0}; // ack 2 -> RUN
    vecs[6]  = '{1'b1, 16'd4, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0}; // cnt 0->1
    vecs[7]  = '{1'b1, 16'd4, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0}; // cnt 1->2
    vecs[8]  = '{1'b1, 16'd4, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0}; // cnt 2->3
    vecs[9]  = '{1'b1, 16'd4, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0}; // tick
    vecs[10] = '{1'b1, 16'd4, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0}; // ack pays it
    vecs[11] = '{1'b1, 16'd4, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0}; // stray ack at 0
    vecs[12] = '{1'b1, 16'd4, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0}; // cnt 2->3
    vecs[13] = '{1'b1, 16'd4, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0}; // tick, ack ignored
    vecs[14] = '{1'b1, 16'd4, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0}; // cnt 0->1
    vecs[15] = '{1'b1, 16'd4, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0}; // cnt 1->2
    vecs[16] = '{1'b1, 16'd4, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0}; // cnt 2->3
    vecs[17] = '{1'b1, 16'd4, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0}; // tick + ack cancel
    vecs[18] = '{1'b0, 16'd4, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0}; // paused

    #2;
    check_output("async_reset_t0", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    do_reset();

    for (int i = 0; i < 19; i++) begin
      apply_stimulus(vecs[i].en, vecs[i].per, vecs[i].ack);
      step();
      check_output($sformatf("vec%0d", i), vecs[i].req, vecs[i].urg,
                   vecs[i].pend, vecs[i].done, vecs[i].ovf);
    end

    // Period 10, no acks: one refresh every 10 cycles, urgent from 6.
    do_reset();
    run_init(16'd10);
    for (int k = 1; k <= 6; k++) begin
      repeat (10) step();
      check_output($sformatf("period10_k%0d", k), 1'b1, (k >= 6), 4'(k), 1'b1, 1'b0);
    end

    // Period 3: saturation at 8, then the lost tick sets overflow.
    do_reset();
    run_init(16'd3);
    repeat (24) step();
    check_output("sat_8", 1'b1, 1'b1, 4'd8, 1'b1, 1'b0);
    repeat (3) step();
    check_output("overflow_set", 1'b1, 1'b1, 4'd8, 1'b1, 1'b1);
    apply_stimulus(1'b0, 16'd3, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      step();
      check_output($sformatf("drain_%0d", i), (8 - i != 0), (8 - i >= 6),
                   4'(8 - i), 1'b1, 1'b1);
    end
    step();
    ref_ack = 1'b0;
    check_output("no_underflow", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);

    // Pause at count 4 for 20 cycles; next tick 6 cycles after re-enable.
    do_reset();
    run_init(16'd10);
    repeat (4) step();
    enable = 1'b0;
    repeat (20) step();
    check_output("paused", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    enable = 1'b1;
    repeat (5) step();
    check_output("resume_5", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    step();
    check_output("resume_6", 1'b1, 1'b0, 4'd1, 1'b1, 1'b0);

    // Lowering the period below count+1 ticks on the next cycle.
    do_reset();
    run_init(16'd10);
    repeat (7) step();
    refresh_period = 16'd4;
    step();
    check_output("lowered_tick", 1'b1, 1'b0, 4'd1, 1'b1, 1'b0);
    repeat (3) step();
    check_output("lowered_wait", 1'b1, 1'b0, 4'd1, 1'b1, 1'b0);
    step();
    check_output("lowered_next", 1'b1, 1'b0, 4'd2, 1'b1, 1'b0);
    refresh_period = 16'd0;
    repeat (10) step();
    check_output("period0_hold", 1'b1, 1'b0, 4'd2, 1'b1, 1'b0);
    refresh_period = 16'd10;
    repeat (9) step();
    check_output("period10_restart_9", 1'b1, 1'b0, 4'd2, 1'b1, 1'b0);
    step();
    check_output("period10_restart_10", 1'b1, 1'b0, 4'd3, 1'b1, 1'b0);

    // Asynchronous reset mid-RUN with five owed refreshes.
    do_reset();
    run_init(16'd1);
    repeat (5) step();
    enable = 1'b0;
    check_output("pre_reset_5", 1'b1, 1'b0, 4'd5, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_output("async_reset_mid", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    repeat (3) step();
    check_output("idle_after_reset", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    enable = 1'b1;
    step();
    check_output("reinit", 1'b1, 1'b0, 4'd2, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/refresh_scheduler.md
REFRESH_SCHEDULER -- requirements
Module: refresh_scheduler

Interface
REQ-001 Parameter SIZE, default 16: width of the refresh interval counter and of refresh_period.
REQ-002 Parameter INIT_REFRESHES, default 2, legal range 1..8: number of refreshes requested during the initialisation burst.
REQ-003 Parameter URGENT_THRESH, default 6, legal range 1..8: pending level at or above which ref_urgent is asserted.
REQ-004 CLK  input  1: single clock; all state updates on rising edge.
REQ-005 RST  input  1: asynchronous, active-high reset.
REQ-006 enable  input  1: starts the scheduler from IDLE; pauses the interval counter in RUN when low.
REQ-007 refresh_period  input  SIZE: refresh interval in CLK cycles; 0 = periodic refresh disabled.
REQ-008 ref_ack  input  1: command sequencer has issued one AUTO REFRESH; counts only while ref_req=1.
REQ-009 ref_req  output  1: at least one refresh is owed.
REQ-010 ref_urgent  output  1: pending_count >= URGENT_THRESH.
REQ-011 pending_count  output  4: number of owed refreshes, 0..8.
REQ-012 init_done  output  1: initialisation burst complete.
REQ-013 overflow  output  1: sticky flag; a periodic tick was lost because pending_count was 8.

Function
REQ-014 State machine SHALL have states IDLE, INIT and RUN; after reset the state is IDLE.
REQ-015 IDLE: counter held at 0, pending_count=0, ref_req=0; on the first cycle enable=1, the next state is INIT and pending_count loads INIT_REFRESHES.
REQ-016 INIT: enable is ignored; each accepted ack (ref_ack=1 and ref_req=1) decrements pending_count; the interval counter is held at 0 and generates no ticks.
REQ-017 INIT->RUN on the accepted ack that takes pending_count to 0; init_done=1 from the next cycle; the interval counter starts at 0 in that same cycle.
REQ-018 RUN: with enable=1 and refresh_period!=0, the counter increments once per cycle; when count == refresh_period-1, it returns to 0 and one tick is generated.
REQ-019 Tick spacing SHALL be exactly refresh_period cycles; refresh_period=1 gives a tick every cycle.
REQ-020 RUN with enable=0: the counter holds its value and no ticks are generated; acks are still accepted.
REQ-021 RUN with refresh_period=0: the counter is held at 0 and no ticks are generated.
REQ-022 If refresh_period is lowered below count+1 while counting, the next cycle SHALL produce a tick and reset the counter; the comparison is count >= refresh_period-1.
REQ-023 A tick increments pending_count and an accepted ack decrements it; a tick and an accepted ack in the same cycle leave it unchanged.
REQ-024 A tick with pending_count=8 and no accepted ack SHALL leave the count at 8 and set overflow; overflow stays set until reset.
REQ-025 ref_ack with pending_count=0 SHALL be ignored, with no underflow.
REQ-026 ref_req, ref_urgent and init_done are decoded from registered state only, not combinationally from inputs.
REQ-027 RUN never returns to IDLE or INIT except through reset.

Reset
REQ-028 RST=1 SHALL immediately force state=IDLE, counter=0, pending_count=0, ref_req=0, ref_urgent=0, init_done=0 and overflow=0.
REQ-029 Reset asserted mid-INIT or mid-RUN SHALL discard all owed refreshes; after release the block waits for enable again.
REQ-030 RST is released synchronously to CLK by the system; the block has no internal synchronizer.

Verification
REQ-031 Reset, then enable=1 with INIT_REFRESHES=2 -> ref_req=1 and pending_count=2; two acks -> pending_count=0 and init_done=1 on the cycle after the second ack.
REQ-032 RUN with refresh_period=10 and no acks -> pending_count increments every 10 cycles; ref_urgent=1 when pending_count reaches 6.
REQ-033 refresh_period=3 with no acks for over 30 cycles -> pending_count saturates at 8 and overflow=1; then 8 acks with no further ticks (enable=0) -> pending_count=0 and overflow still 1.
REQ-034 pending_count=1, with a tick and an accepted ack in the same cycle -> pending_count stays 1; a stray ref_ack at pending_count=0 -> no change.
REQ-035 enable dropped at count=4 with period 10 for 20 cycles, then re-raised -> next tick arrives 6 cycles after re-enable.
REQ-036 RST pulsed asynchronously mid-RUN with pending_count=5 -> all outputs 0 before the next CLK edge; state is IDLE.
